// File: rtl/ws2812_frame_sched.sv
// Frame scheduler for an 8x8 WS2812 chain: arbitrates two pixel sources, sequences frames, enforces latch gap.
// Optional brightness reduction on cfg_data is enabled by defining WS_DIM_EN.
module ws2812_frame_sched #(
    parameter int NUM_PIX      = 64,
    parameter int PIX_W        = 6,
    parameter int PWR_WAIT_CYC = 1_000_000,
    parameter int GAP_CYC      = 15_000,
    parameter int TIMEOUT_CYC  = 2_000_000,
    parameter int DIM_SHIFT    = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [1:0]       req,
    input  logic [23:0]      src0_data,
    input  logic [23:0]      src1_data,
    input  logic             cfg_start,
    output logic             ws2812_start,
    output logic [PIX_W-1:0] cfg_num,
    output logic [23:0]      cfg_data,
    output logic             grant,
    output logic             busy,
    output logic             frame_done,
    output logic             err_timeout
);

    localparam int MAX_A   = (PWR_WAIT_CYC > GAP_CYC) ? PWR_WAIT_CYC : GAP_CYC;
    localparam int CNT_LIM = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
    localparam int CW      = $clog2(CNT_LIM + 1);

    localparam logic [CW-1:0]    PWR_LAST = CW'(PWR_WAIT_CYC - 1);
    localparam logic [CW-1:0]    GAP_LAST = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0]    TO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIX - 1);

    typedef enum logic [2:0] {
        S_PWR   = 3'd0,
        S_IDLE  = 3'd1,
        S_START = 3'd2,
        S_XFER  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PIX_W-1:0] num_q, num_d;
    logic [1:0]       pend_q, pend_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             pick_s;
    logic [23:0]      sel_s;

    // Each colour byte shifted on its own so no bits leak between G, R and B.
    function automatic logic [23:0] dim_grb(input logic [23:0] w);
        logic [7:0] g, r, b;
        g = w[23:16] >> DIM_SHIFT;
        r = w[15:8]  >> DIM_SHIFT;
        b = w[7:0]   >> DIM_SHIFT;
        return {g, r, b};
    endfunction

    // State, counter, arbitration and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_PWR;
            cnt_q   <= '0;
            num_q   <= '0;
            pend_q  <= 2'b00;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Round-robin pick: with both pending, prefer the source that did not finish last.
    always_comb begin
        if (pend_q == 2'b11) begin
            pick_s = ~last_q;
        end else begin
            pick_s = pend_q[1];
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        pend_d  = pend_q | req;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            S_PWR: begin
                if (cnt_q == PWR_LAST) begin
                    cnt_d     = '0;
                    pend_d[0] = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_IDLE: begin
                if (pend_q != 2'b00) begin
                    grant_d        = pick_s;
                    pend_d[pick_s] = req[pick_s];
                    num_d          = '0;
                    cnt_d          = '0;
                    state_d        = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_XFER;
            end
            S_XFER: begin
                if (cfg_start) begin
                    cnt_d = '0;
                    if (num_q == PIX_LAST) begin
                        num_d   = '0;
                        last_d  = grant_q;
                        state_d = S_GAP;
                    end else begin
                        num_d = num_q + PIX_W'(1);
                    end
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = '0;
                    num_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_PWR;
                cnt_d   = '0;
                num_d   = '0;
            end
        endcase
    end

    // Output pulses; ws2812_start trails the START state by one cycle.
    always_comb begin
        start_d = (state_q == S_START);
        done_d  = (state_q == S_XFER) && cfg_start && (num_q == PIX_LAST);
        err_d   = (state_q == S_XFER) && !cfg_start && (cnt_q == TO_LAST);
        case (state_d)
            S_START, S_XFER, S_GAP: busy_d = 1'b1;
            default:                busy_d = 1'b0;
        endcase
    end

    assign sel_s = grant_q ? src1_data : src0_data;

`ifdef WS_DIM_EN
    assign cfg_data = dim_grb(sel_s);
`else
    assign cfg_data = sel_s;
`endif

    assign ws2812_start = start_q;
    assign cfg_num      = num_q;
    assign grant        = grant_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Directed self-checking bench for ws2812_frame_sched with shortened timing parameters.
module tb_ws2812_frame_sched;

    localparam int NUM_PIX = 64;
    localparam int PIX_W   = 6;

`ifdef WS_DIM_EN
    localparam logic [23:0] EXP_S0A = 24'h001F00;
    localparam logic [23:0] EXP_S1  = 24'h02060A;
    localparam logic [23:0] EXP_S0B = 24'h1F1002;
`else
    localparam logic [23:0] EXP_S0A = 24'h00FF00;
    localparam logic [23:0] EXP_S1  = 24'h123456;
    localparam logic [23:0] EXP_S0B = 24'hF88010;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req;
    logic [23:0]      src0_data;
    logic [23:0]      src1_data;
    logic             cfg_start;
    logic             ws2812_start;
    logic [PIX_W-1:0] cfg_num;
    logic [23:0]      cfg_data;
    logic             grant;
    logic             busy;
    logic             frame_done;
    logic             err_timeout;

    int vec = 0;
    int mis = 0;

    always #5 clk = ~clk;

    ws2812_frame_sched #(
        .NUM_PIX     (NUM_PIX),
        .PIX_W       (PIX_W),
        .PWR_WAIT_CYC(10),
        .GAP_CYC     (5),
        .TIMEOUT_CYC (50),
        .DIM_SHIFT   (3)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .req         (req),
        .src0_data   (src0_data),
        .src1_data   (src1_data),
        .cfg_start   (cfg_start),
        .ws2812_start(ws2812_start),
        .cfg_num     (cfg_num),
        .cfg_data    (cfg_data),
        .grant       (grant),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_timeout (err_timeout)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulses(input int n, input int spacing);
        repeat (n) begin
            cfg_start = 1'b1;
            tick(1);
            cfg_start = 1'b0;
            tick(spacing - 1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 2'b00;
        cfg_start = 1'b0;
        src0_data = 24'h00FF00;
        src1_data = 24'h123456;
        tick(3);
        chk("rst_start", {31'd0, ws2812_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_num", {26'd0, cfg_num}, 32'd0);
        chk("rst_grant", {31'd0, grant}, 32'd0);
        chk("rst_flags", {30'd0, frame_done, err_timeout}, 32'd0);

        // power-up: start pulse lands exactly 12 edges after release
        rst_n = 1'b1;
        tick(11);
        chk("pwr_start_c11", {31'd0, ws2812_start}, 32'd0);
        chk("pwr_busy_c11", {31'd0, busy}, 32'd1);
        cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        chk("pwr_start_c12", {31'd0, ws2812_start}, 32'd1);
        chk("pwr_grant", {31'd0, grant}, 32'd0);
        chk("start_cfg_ignored", {26'd0, cfg_num}, 32'd0);
        chk("data_src0", {8'd0, cfg_data}, {8'd0, EXP_S0A});
        tick(1);
        chk("start_one_cycle", {31'd0, ws2812_start}, 32'd0);

        // full frame at one cfg_start every 4 clocks
        pulses(30, 4);
        chk("num_30", {26'd0, cfg_num}, 32'd30);
        pulses(33, 4);
        chk("num_63", {26'd0, cfg_num}, 32'd63);
        chk("no_done_early", {31'd0, frame_done}, 32'd0);
        cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        chk("done_pulse", {31'd0, frame_done}, 32'd1);
        chk("num_wrap", {26'd0, cfg_num}, 32'd0);
        tick(1);
        chk("done_one_cycle", {31'd0, frame_done}, 32'd0);
        cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        chk("gap_cfg_ignored", {26'd0, cfg_num}, 32'd0);
        tick(2);
        chk("gap_busy_c4", {31'd0, busy}, 32'd1);
        tick(1);
        chk("gap_idle_c5", {31'd0, busy}, 32'd0);
        cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        chk("idle_cfg_ignored", {26'd0, cfg_num}, 32'd0);
        tick(3);
        chk("idle_no_start", {30'd0, ws2812_start, busy}, 32'd0);

        // both sources request after a src0 frame: src1 wins
        req = 2'b11;
        tick(1);
        req = 2'b00;
        tick(1);
        chk("rr_latency_c1", {31'd0, ws2812_start}, 32'd0);
        tick(1);
        chk("rr_start", {31'd0, ws2812_start}, 32'd1);
        chk("rr_grant1", {31'd0, grant}, 32'd1);
        chk("data_src1", {8'd0, cfg_data}, {8'd0, EXP_S1});
        req = 2'b10;
        tick(1);
        req = 2'b00;
        pulses(64, 1);
        chk("src1_done", {31'd0, frame_done}, 32'd1);
        tick(6);
        chk("b2b_gap_c6", {31'd0, ws2812_start}, 32'd0);
        tick(1);
        chk("b2b_start_c7", {31'd0, ws2812_start}, 32'd1);
        chk("rr_grant0", {31'd0, grant}, 32'd0);
        chk("data_src0_again", {8'd0, cfg_data}, {8'd0, EXP_S0A});
        pulses(64, 1);
        chk("src0_done", {31'd0, frame_done}, 32'd1);
        tick(7);
        chk("held_req_start", {31'd0, ws2812_start}, 32'd1);
        chk("held_req_grant1", {31'd0, grant}, 32'd1);

        // watchdog abort after 50 idle cycles in transfer
        pulses(3, 1);
        chk("wd_num3", {26'd0, cfg_num}, 32'd3);
        tick(49);
        chk("wd_not_yet", {31'd0, err_timeout}, 32'd0);
        chk("wd_num_held", {26'd0, cfg_num}, 32'd3);
        tick(1);
        chk("wd_err", {31'd0, err_timeout}, 32'd1);
        chk("wd_num_clr", {26'd0, cfg_num}, 32'd0);
        chk("wd_no_done", {31'd0, frame_done}, 32'd0);
        tick(4);
        chk("wd_gap_busy", {31'd0, busy}, 32'd1);
        chk("wd_err_cleared", {31'd0, err_timeout}, 32'd0);
        tick(1);
        chk("wd_idle", {31'd0, busy}, 32'd0);
        chk("wd_grant_held", {31'd0, grant}, 32'd1);

        // new data word, then reset mid-frame
        src0_data = 24'hF88010;
        req = 2'b01;
        tick(1);
        req = 2'b00;
        tick(2);
        chk("s0_start", {31'd0, ws2812_start}, 32'd1);
        chk("s0_grant", {31'd0, grant}, 32'd0);
        chk("dim_data", {8'd0, cfg_data}, {8'd0, EXP_S0B});
        pulses(30, 1);
        chk("mid_num30", {26'd0, cfg_num}, 32'd30);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {24'd0, cfg_num, grant, busy}, 32'd0);
        chk("mid_rst_pulses", {29'd0, ws2812_start, frame_done, err_timeout}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(11);
        chk("re_pwr_c11", {31'd0, ws2812_start}, 32'd0);
        tick(1);
        chk("re_pwr_c12", {31'd0, ws2812_start}, 32'd1);
        chk("re_pwr_grant", {31'd0, grant}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
